// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer push lanes and the common data bus broadcast.
// master is the producer/listener side, slave is the arbiter side.
interface cdb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;
    logic              alu_full;

    logic              lsb_valid;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_data;
    logic              lsb_full;

    logic              br_valid;
    logic [TAG_W-1:0]  br_tag;
    logic [DATA_W-1:0] br_data;
    logic              br_full;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [1:0]        cdb_src;

    modport master (
        output alu_valid, alu_tag, alu_data,
        output lsb_valid, lsb_tag, lsb_data,
        output br_valid, br_tag, br_data,
        input  alu_full, lsb_full, br_full,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  alu_valid, alu_tag, alu_data,
        input  lsb_valid, lsb_tag, lsb_data,
        input  br_valid, br_tag, br_data,
        output alu_full, lsb_full, br_full,
        output cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three producer FIFOs (0=ALU 1=LSB 2=Branch) feeding one
// registered common data bus, one round-robin pick per enabled cycle.
module cdb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clear,
    cdb_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [TAG_W-1:0]  tag_mem  [3][DEPTH];
    logic [DATA_W-1:0] data_mem [3][DEPTH];
    logic [PW-1:0]     wr_ptr   [3];
    logic [PW-1:0]     rd_ptr   [3];
    logic [CW-1:0]     count    [3];
    logic [1:0]        rr_last;

    logic [2:0]        push_v;
    logic [2:0]        full;
    logic [2:0]        nonempty;
    logic [2:0]        push_ok;
    logic [2:0]        pop_ok;
    logic [TAG_W-1:0]  push_tag  [3];
    logic [DATA_W-1:0] push_data [3];
    logic [TAG_W-1:0]  head_tag  [3];
    logic [DATA_W-1:0] head_data [3];

    logic [1:0]        c0;
    logic [1:0]        c1;
    logic [1:0]        c2;
    logic [1:0]        win;
    logic              any;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [1:0]        cdb_src_q;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Map the named producer lanes onto producer-indexed arrays.
    always_comb begin
        push_v       = {bus.br_valid, bus.lsb_valid, bus.alu_valid};
        push_tag[0]  = bus.alu_tag;
        push_tag[1]  = bus.lsb_tag;
        push_tag[2]  = bus.br_tag;
        push_data[0] = bus.alu_data;
        push_data[1] = bus.lsb_data;
        push_data[2] = bus.br_data;
    end

    // Occupancy flags and FIFO heads as they stand before the edge.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            full[i]      = (count[i] == FULL_CNT);
            nonempty[i]  = (count[i] != '0);
            head_tag[i]  = tag_mem[i][rd_ptr[i]];
            head_data[i] = data_mem[i][rd_ptr[i]];
        end
    end

    assign bus.alu_full = full[0];
    assign bus.lsb_full = full[1];
    assign bus.br_full  = full[2];

    // Round-robin search starting after the last winner; push and pop enables.
    always_comb begin
        c0  = rr_next(rr_last);
        c1  = rr_next(c0);
        c2  = rr_next(c1);
        win = rr_last;
        any = 1'b1;
        if (nonempty[c0]) begin
            win = c0;
        end else if (nonempty[c1]) begin
            win = c1;
        end else if (nonempty[c2]) begin
            win = c2;
        end else begin
            any = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            push_ok[i] = push_v[i] & ~full[i];
            pop_ok[i]  = any & (win == 2'(i));
        end
    end

    // Pointers and counts; a push into a full FIFO is simply dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < 3; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop_ok[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (push_ok[i] && !pop_ok[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!push_ok[i] && pop_ok[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
        end
    end

    // Entry storage is not reset; the pointers decide which slots are live.
    always_ff @(posedge clk) begin
        if (rst && rdy && !clear) begin
            for (int i = 0; i < 3; i++) begin
                if (push_ok[i]) begin
                    tag_mem[i][wr_ptr[i]]  <= push_tag[i];
                    data_mem[i][wr_ptr[i]] <= push_data[i];
                end
            end
        end
    end

    // Registered one-cycle broadcast of the winning head; zeros when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= 2'd0;
            rr_last     <= 2'd2;
        end else if (clear) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= 2'd0;
            rr_last     <= 2'd2;
        end else if (rdy) begin
            cdb_valid_q <= any;
            cdb_tag_q   <= any ? head_tag[win]  : '0;
            cdb_data_q  <= any ? head_data[win] : '0;
            cdb_src_q   <= any ? win : 2'd0;
            if (any) rr_last <= win;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule
